// File: rtl/s_mem_responder.sv
// rtl/s_mem_responder.sv - two-port req/gnt responder for the RC4 S-array with a 2-stage tagged read pipeline
// Define S_MEM_RR_ARB_EN for round-robin arbitration; default is fixed priority with A over B.
module s_mem_responder #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    logic          a_wins;
    logic          acc_valid;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_tag_b_q, s1_tag_b_d;
    logic [DW-1:0] s1_data_q,  s1_data_d;
    logic          rvalid_a_q, rvalid_a_d;
    logic          rvalid_b_q, rvalid_b_d;
    logic [DW-1:0] rdata_a_q,  rdata_a_d;
    logic [DW-1:0] rdata_b_q,  rdata_b_d;

`ifdef S_MEM_RR_ARB_EN
    // High when B took the last contended grant, so A is owed the next one.
    logic last_b_q, last_b_d;

    always_comb begin
        a_wins   = last_b_q;
        last_b_d = last_b_q;
        if (rst_n && req_a && req_b) begin
            last_b_d = gnt_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    always_comb begin
        a_wins = 1'b1;
    end
`endif

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_n) begin
            if (req_a && (!req_b || a_wins)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    always_comb begin
        acc_valid = gnt_a | gnt_b;
        acc_we    = gnt_a ? we_a    : we_b;
        acc_addr  = gnt_a ? addr_a  : addr_b;
        acc_wdata = gnt_a ? wdata_a : wdata_b;
    end

    // Storage is deliberately left out of reset; grants are already gated by rst_n.
    always_ff @(posedge clk) begin
        if (acc_valid && acc_we) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    always_comb begin
        s1_valid_d = acc_valid & ~acc_we;
        s1_tag_b_d = gnt_b;
        s1_data_d  = mem_q[acc_addr];
        rvalid_a_d = s1_valid_q & ~s1_tag_b_q;
        rvalid_b_d = s1_valid_q &  s1_tag_b_q;
        rdata_a_d  = rvalid_a_d ? s1_data_q : rdata_a_q;
        rdata_b_d  = rvalid_b_d ? s1_data_q : rdata_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_tag_b_q <= 1'b0;
            s1_data_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_b_q <= s1_tag_b_d;
            s1_data_q  <= s1_data_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign busy     = s1_valid_q | rvalid_a_q | rvalid_b_q;

endmodule

// File: tb/tb_s_mem_responder.sv
// tb/tb_s_mem_responder.sv - directed and randomized bench for s_mem_responder against a queue-based model
module tb_s_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [7:0] addr_a = 8'h00, addr_b = 8'h00, wdata_a = 8'h00, wdata_b = 8'h00;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
    logic [7:0] rdata_a, rdata_b;

    s_mem_responder #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    // Reference model: responses are queued with the cycle they become visible.
    typedef struct {
        int       due;
        bit       port_b;
        bit [7:0] data;
        bit       known;
    } rsp_t;

    rsp_t     pend[$];
    bit [7:0] mmem [256];
    bit       mknown [256];
    bit       m_rv_a, m_rv_b;
    bit [7:0] m_rd_a, m_rd_b;
    bit       m_rd_a_k, m_rd_b_k;
    bit       a_first;
    int       cyc = 0;
    bit       m_ga, m_gb, m_we;
    bit [7:0] m_addr, m_wd;
    rsp_t     m_r;

    function automatic bit win_a(input bit ra, input bit rb, input bit rn);
        if (!rn) return 1'b0;
        if (ra && rb) begin
`ifdef S_MEM_RR_ARB_EN
            return a_first;
`else
            return 1'b1;
`endif
        end
        return ra;
    endfunction

    function automatic bit win_b(input bit ra, input bit rb, input bit rn);
        return rn && rb && !win_a(ra, rb, rn);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            m_rv_a = 1'b0;  m_rv_b = 1'b0;
            m_rd_a = 8'h00; m_rd_b = 8'h00;
            m_rd_a_k = 1'b1; m_rd_b_k = 1'b1;
            a_first = 1'b1;
        end else begin
            m_ga = win_a(req_a, req_b, 1'b1);
            m_gb = win_b(req_a, req_b, 1'b1);
            cyc++;
            m_rv_a = 1'b0;
            m_rv_b = 1'b0;
            while (pend.size() > 0 && pend[0].due == cyc) begin
                m_r = pend.pop_front();
                if (m_r.port_b) begin
                    m_rv_b = 1'b1; m_rd_b = m_r.data; m_rd_b_k = m_r.known;
                end else begin
                    m_rv_a = 1'b1; m_rd_a = m_r.data; m_rd_a_k = m_r.known;
                end
            end
            if (req_a && req_b) a_first = m_gb;
            if (m_ga || m_gb) begin
                m_we   = m_ga ? we_a    : we_b;
                m_addr = m_ga ? addr_a  : addr_b;
                m_wd   = m_ga ? wdata_a : wdata_b;
                if (m_we) begin
                    mmem[m_addr]   = m_wd;
                    mknown[m_addr] = 1'b1;
                end else begin
                    pend.push_back('{due: cyc + 1, port_b: m_gb, data: mmem[m_addr], known: mknown[m_addr]});
                end
            end
        end
    end

    always @(negedge clk) begin
        chk1("gnt_a", gnt_a, win_a(req_a, req_b, rst_n));
        chk1("gnt_b", gnt_b, win_b(req_a, req_b, rst_n));
        chk1("rvalid_a", rvalid_a, m_rv_a);
        chk1("rvalid_b", rvalid_b, m_rv_b);
        chk1("busy", busy, pend.size() > 0 || m_rv_a || m_rv_b);
        if (m_rd_a_k) chk8("rdata_a", rdata_a, m_rd_a);
        if (m_rd_b_k) chk8("rdata_b", rdata_b, m_rd_b);
    end

    // Per-step output log used by the directed literal checks.
    logic       lg_ga[16], lg_gb[16], lg_rva[16], lg_rvb[16], lg_busy[16];
    logic [7:0] lg_rda[16], lg_rdb[16];
    int         si = 0;

    task automatic step_core();
        @(negedge clk);
        lg_ga[si] = gnt_a;   lg_gb[si] = gnt_b;
        lg_rva[si] = rvalid_a; lg_rvb[si] = rvalid_b;
        lg_rda[si] = rdata_a;  lg_rdb[si] = rdata_b;
        lg_busy[si] = busy;
        si++;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic idle();
        step_core();
    endtask
    task automatic wr_a(input logic [7:0] a, input logic [7:0] d);
        req_a = 1'b1; we_a = 1'b1; addr_a = a; wdata_a = d; step_core();
    endtask
    task automatic rd_a(input logic [7:0] a);
        req_a = 1'b1; we_a = 1'b0; addr_a = a; step_core();
    endtask
    task automatic wr_b(input logic [7:0] a, input logic [7:0] d);
        req_b = 1'b1; we_b = 1'b1; addr_b = a; wdata_b = d; step_core();
    endtask
    task automatic rd_b(input logic [7:0] a);
        req_b = 1'b1; we_b = 1'b0; addr_b = a; step_core();
    endtask
    task automatic rd_both(input logic [7:0] a, input logic [7:0] b);
        req_a = 1'b1; we_a = 1'b0; addr_a = a;
        req_b = 1'b1; we_b = 1'b0; addr_b = b;
        step_core();
    endtask

    bit       pa, pb, ga, gb;
    logic     exp_a;

    initial begin
        req_a = 1'b1;
        req_b = 1'b1;
        @(negedge clk);
        chk1("rst_gnt_a", gnt_a, 1'b0);
        chk1("rst_gnt_b", gnt_b, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rvalid_a", rvalid_a, 1'b0);
        chk8("rst_rdata_b", rdata_b, 8'h00);
        @(posedge clk);
        #1;
        req_a = 1'b0; req_b = 1'b0; rst_n = 1'b1;

        // Write then read on port A
        si = 0;
        wr_a(8'h04, 8'h32); rd_a(8'h04); idle(); idle(); idle();
        chk1("t1_busy_s1", lg_busy[2], 1'b1);
        chk1("t1_rv_early", lg_rva[2], 1'b0);
        chk1("t1_rv", lg_rva[3], 1'b1);
        chk8("t1_rd", lg_rda[3], 8'h32);
        chk1("t1_busy_s2", lg_busy[3], 1'b1);
        chk1("t1_busy_end", lg_busy[4], 1'b0);
        chk8("t1_rd_hold", lg_rda[4], 8'h32);

        // Back-to-back reads on port B, including address 0xFF
        wr_a(8'h00, 8'h10); wr_a(8'h01, 8'h11); wr_a(8'hFF, 8'hEE);
        si = 0;
        rd_b(8'h00); rd_b(8'h01); rd_b(8'hFF); idle(); idle(); idle();
        chk1("t2_rv0", lg_rvb[2], 1'b1); chk8("t2_rd0", lg_rdb[2], 8'h10);
        chk1("t2_rv1", lg_rvb[3], 1'b1); chk8("t2_rd1", lg_rdb[3], 8'h11);
        chk1("t2_rv2", lg_rvb[4], 1'b1); chk8("t2_rd2", lg_rdb[4], 8'hEE);
        chk1("t2_rv_end", lg_rvb[5], 1'b0);

        // Contention for 4 cycles
        si = 0;
        for (int i = 0; i < 4; i++) rd_both(8'h00, 8'h01);
        idle(); idle();
        for (int i = 0; i < 4; i++) begin
`ifdef S_MEM_RR_ARB_EN
            exp_a = (i % 2 == 0);
`else
            exp_a = 1'b1;
`endif
            chk1($sformatf("t3_gnt_a%0d", i), lg_ga[i], exp_a);
            chk1($sformatf("t3_gnt_b%0d", i), lg_gb[i], !exp_a);
        end

        // Swap sequence on port B, observed from port A
        wr_a(8'h00, 8'd50); wr_a(8'h04, 8'd2);
        si = 0;
        rd_b(8'h00); rd_b(8'h04); wr_b(8'h00, 8'd2); wr_b(8'h04, 8'd50);
        chk8("t4_rd_i", lg_rdb[2], 8'd50);
        chk8("t4_rd_j", lg_rdb[3], 8'd2);
        si = 0;
        rd_a(8'h00); rd_a(8'h04); idle(); idle();
        chk8("t4_a0", lg_rda[2], 8'd2);
        chk8("t4_a4", lg_rda[3], 8'd50);

        // Reset during a read
        si = 0;
        rd_a(8'h04);
        rst_n = 1'b0;
        rd_a(8'h04); idle();
        rst_n = 1'b1;
        rd_a(8'h04); idle(); idle();
        chk1("t5_gnt_rst", lg_ga[1], 1'b0);
        chk1("t5_rv1", lg_rva[1], 1'b0);
        chk1("t5_rv2", lg_rva[2], 1'b0);
        chk1("t5_busy", lg_busy[1], 1'b0);
        chk8("t5_rd_zero", lg_rda[2], 8'h00);
        chk1("t5_rv_fresh", lg_rva[5], 1'b1);
        chk8("t5_rd_fresh", lg_rda[5], 8'd50);

        // Tag isolation
        si = 0;
        rd_a(8'h04); rd_b(8'h00); idle(); idle(); idle();
        chk1("t6_rva", lg_rva[2], 1'b1);
        chk1("t6_rvb_off", lg_rvb[2], 1'b0);
        chk1("t6_rvb", lg_rvb[3], 1'b1);
        chk8("t6_rda_hold", lg_rda[3], 8'd50);
        chk8("t6_rda", lg_rda[4], 8'd50);
        chk8("t6_rdb", lg_rdb[4], 8'd2);

        // Randomized traffic with held requests and occasional reset
        pa = 1'b0; pb = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1'b1; we_a = 1'($urandom_range(0, 1));
                addr_a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
                wdata_a = 8'($urandom);
            end else if (pa && $urandom_range(0, 7) == 0) begin
                addr_a = 8'($urandom_range(0, 7));
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1; we_b = 1'($urandom_range(0, 1));
                addr_b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                wdata_b = 8'($urandom);
            end else if (pb && $urandom_range(0, 7) == 0) begin
                wdata_b = 8'($urandom);
            end
            req_a = pa; req_b = pb;
            rst_n = (n % 700 != 699);
            @(negedge clk);
            ga = gnt_a; gb = gnt_b;
            @(posedge clk);
            #1;
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
        rst_n = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
